// File: rtl/program_loader.sv
// Boot-time loader: assembles a little-endian byte stream into IMEM (32-bit)
// and DMEM (64-bit) words, then enables the cpu until halt.
module program_loader #(
  parameter int IMEM_DEPTH = 512,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        start,
  input  logic        halt,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  output logic        cpu_enable,
  output logic        busy,
  output logic        error
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_HDR   | collecting 4 header bytes (icount, dcount)
  // S_IMEM  | assembling/writing 32-bit instruction words
  // S_DMEM  | assembling/writing 64-bit data words
  // S_RUN   | cpu enabled until halt
  // S_ERROR | header rejected, waiting for a retry start
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_IMEM, S_DMEM, S_RUN, S_ERROR} state_t;

  localparam logic [16:0] L_IMAX = 17'(IMEM_DEPTH);
  localparam logic [16:0] L_DMAX = 17'(DMEM_DEPTH);

  state_t      r_state;
  logic [2:0]  r_byte_cnt;
  logic [15:0] r_word_cnt;
  logic [15:0] r_icount;
  logic [15:0] r_dcount;
  logic [55:0] r_asm;
  logic [63:0] r_addr_i;
  logic        r_wen_i;
  logic [31:0] r_wdata_i;
  logic [63:0] r_addr_d;
  logic        r_wen_d;
  logic [63:0] r_wdata_d;
  logic        r_cpu_en;
  logic        r_error;

  logic        w_load;
  logic        w_acc;
  logic [15:0] w_hdr_icnt;
  logic [15:0] w_hdr_dcnt;
  logic        w_hdr_bad;
  logic [31:0] w_word_i;
  logic [63:0] w_word_d;

  // Bytes shift in from the top, so the first byte of a word lands lowest.
  assign w_load     = (r_state == S_HDR) || (r_state == S_IMEM) || (r_state == S_DMEM);
  assign in_ready   = w_load && !r_wen_i && !r_wen_d;
  assign w_acc      = in_valid && in_ready;
  assign w_hdr_icnt = {r_asm[47:40], r_asm[39:32]};
  assign w_hdr_dcnt = {in_data, r_asm[55:48]};
  assign w_hdr_bad  = ({1'b0, w_hdr_icnt} > L_IMAX) || ({1'b0, w_hdr_dcnt} > L_DMAX);
  assign w_word_i   = {in_data, r_asm[55:32]};
  assign w_word_d   = {in_data, r_asm};

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state    <= S_IDLE;
      r_byte_cnt <= '0;
      r_word_cnt <= '0;
      r_icount   <= '0;
      r_dcount   <= '0;
      r_asm      <= '0;
      r_addr_i   <= '0;
      r_wen_i    <= 1'b0;
      r_wdata_i  <= '0;
      r_addr_d   <= '0;
      r_wen_d    <= 1'b0;
      r_wdata_d  <= '0;
      r_cpu_en   <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_wen_i <= 1'b0;
      r_wen_d <= 1'b0;
      if (w_acc) begin
        r_asm      <= {in_data, r_asm[55:8]};
        r_byte_cnt <= r_byte_cnt + 3'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_HDR;
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_error    <= 1'b0;
          end
        end
        S_HDR: begin
          if (w_acc && r_byte_cnt == 3'd3) begin
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_icount   <= w_hdr_icnt;
            r_dcount   <= w_hdr_dcnt;
            if (w_hdr_bad) begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end else if (w_hdr_icnt != 16'd0) begin
              r_state <= S_IMEM;
            end else if (w_hdr_dcnt != 16'd0) begin
              r_state <= S_DMEM;
            end else begin
              r_state  <= S_RUN;
              r_cpu_en <= 1'b1;
            end
          end
        end
        S_IMEM: begin
          // Word index advances at the end of its pulse, so the exit test sees the written word.
          if (r_wen_i) begin
            if (r_word_cnt == r_icount - 16'd1) begin
              r_word_cnt <= '0;
              if (r_dcount != 16'd0) begin
                r_state <= S_DMEM;
              end else begin
                r_state  <= S_RUN;
                r_cpu_en <= 1'b1;
              end
            end else begin
              r_word_cnt <= r_word_cnt + 16'd1;
            end
          end else if (w_acc && r_byte_cnt == 3'd3) begin
            r_byte_cnt <= '0;
            r_wen_i    <= 1'b1;
            r_addr_i   <= {46'd0, r_word_cnt, 2'b00};
            r_wdata_i  <= w_word_i;
          end
        end
        S_DMEM: begin
          if (r_wen_d) begin
            if (r_word_cnt == r_dcount - 16'd1) begin
              r_word_cnt <= '0;
              r_state    <= S_RUN;
              r_cpu_en   <= 1'b1;
            end else begin
              r_word_cnt <= r_word_cnt + 16'd1;
            end
          end else if (w_acc && r_byte_cnt == 3'd7) begin
            r_byte_cnt <= '0;
            r_wen_d    <= 1'b1;
            r_addr_d   <= {45'd0, r_word_cnt, 3'b000};
            r_wdata_d  <= w_word_d;
          end
        end
        S_RUN: begin
          if (halt) begin
            r_state  <= S_IDLE;
            r_cpu_en <= 1'b0;
          end
        end
        S_ERROR: begin
          if (start) begin
            r_state    <= S_HDR;
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_error    <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign addr_ext    = r_addr_i;
  assign wen_ext     = r_wen_i;
  assign ren_ext     = 1'b0;
  assign wdata_ext   = r_wdata_i;
  assign addr_ext_2  = r_addr_d;
  assign wen_ext_2   = r_wen_d;
  assign ren_ext_2   = 1'b0;
  assign wdata_ext_2 = r_wdata_d;
  assign cpu_enable  = r_cpu_en;
  assign busy        = w_load;
  assign error       = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: streams are built from counts, and the
// expected memory writes and timing are derived from the byte stream itself.
module tb_program_loader;

  localparam int IMAX = 512;
  localparam int DMAX = 1024;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic        cpu_enable;
  logic        busy;
  logic        error;

  program_loader #(.IMEM_DEPTH(IMAX), .DMEM_DEPTH(DMAX)) dut (
    .clk(clk), .arst_n(arst_n), .start(start), .halt(halt),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .cpu_enable(cpu_enable), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic [63:0] wi_addr[$], wi_data[$], wd_addr[$], wd_data[$];
  int          wi_cyc[$], wd_cyc[$];
  int          rise_cyc = -1;
  logic        prev_en = 1'b0;

  // Write-port monitor with per-pulse invariants
  always @(negedge clk) begin
    if (arst_n) begin
      if (wen_ext) begin
        wi_addr.push_back(addr_ext); wi_data.push_back({32'd0, wdata_ext}); wi_cyc.push_back(cyc);
      end
      if (wen_ext_2) begin
        wd_addr.push_back(addr_ext_2); wd_data.push_back(wdata_ext_2); wd_cyc.push_back(cyc);
      end
      if (wen_ext || wen_ext_2) begin
        chk("ready_low_in_pulse", {63'd0, in_ready}, 64'd0);
        chk("cpu_off_in_pulse", {63'd0, cpu_enable}, 64'd0);
        chk("single_wen", {63'd0, wen_ext & wen_ext_2}, 64'd0);
      end
      if (cpu_enable && !prev_en) rise_cyc = cyc;
    end
    prev_en = cpu_enable;
  end

  logic [7:0] stream[$];
  int         acc_cyc[$];

  task automatic make_stream(input int ic, input int dc, input bit payload);
    stream.delete();
    stream.push_back(8'(ic)); stream.push_back(8'(ic >> 8));
    stream.push_back(8'(dc)); stream.push_back(8'(dc >> 8));
    if (payload)
      for (int i = 0; i < ic * 4 + dc * 8; i++) stream.push_back(8'($urandom));
  endtask

  task automatic send_bytes(input int gap_pct, input int n);
    int idx = 0;
    int budget = 0;
    while (idx < n && budget < 20000) begin
      @(negedge clk);
      budget++;
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data  = in_valid ? stream[idx] : 8'($urandom);
      #1;
      if (in_valid && in_ready) begin
        acc_cyc.push_back(cyc + 1);
        idx++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (idx < n) chk("stream_timeout", 64'(idx), 64'(n));
  endtask

  task automatic begin_load();
    wi_addr.delete(); wi_data.delete(); wi_cyc.delete();
    wd_addr.delete(); wd_data.delete(); wd_cyc.delete();
    acc_cyc.delete();
    rise_cyc = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    chk("error_clear_after_start", {63'd0, error}, 64'd0);
  endtask

  task automatic run_load(input int gap_pct);
    int ic, dc, w, dbase, n;
    bit over;
    logic [63:0] ew;
    ic = int'({stream[1], stream[0]});
    dc = int'({stream[3], stream[2]});
    over = (ic > IMAX) || (dc > DMAX);
    n = stream.size();
    begin_load();
    send_bytes(gap_pct, n);
    w = 0;
    while (!(cpu_enable || error) && w < 200) begin
      @(negedge clk); w++;
    end
    @(negedge clk);
    chk("outcome_err_cpu", {62'd0, error, cpu_enable}, over ? 64'd2 : 64'd1);
    chk("ready_low_after", {63'd0, in_ready}, 64'd0);
    chk("busy_low_after", {63'd0, busy}, 64'd0);
    chk("imem_writes", 64'(wi_addr.size()), over ? 64'd0 : 64'(ic));
    chk("dmem_writes", 64'(wd_addr.size()), over ? 64'd0 : 64'(dc));
    if (!over && acc_cyc.size() == n) begin
      for (int j = 0; j < ic && j < wi_addr.size(); j++) begin
        ew = {32'd0, stream[7+4*j], stream[6+4*j], stream[5+4*j], stream[4+4*j]};
        chk("imem_addr", wi_addr[j], 64'(4 * j));
        chk("imem_data", wi_data[j], ew);
        chk("imem_pulse_cyc", 64'(wi_cyc[j]), 64'(acc_cyc[7+4*j]));
      end
      dbase = 4 + 4 * ic;
      for (int j = 0; j < dc && j < wd_addr.size(); j++) begin
        for (int b = 0; b < 8; b++) ew[8*b +: 8] = stream[dbase + 8*j + b];
        chk("dmem_addr", wd_addr[j], 64'(8 * j));
        chk("dmem_data", wd_data[j], ew);
        chk("dmem_pulse_cyc", 64'(wd_cyc[j]), 64'(acc_cyc[dbase + 8*j + 7]));
      end
      if (ic + dc > 0) chk("cpu_en_cyc", 64'(rise_cyc), 64'(acc_cyc[n-1] + 1));
      else             chk("cpu_en_cyc_zero", 64'(rise_cyc), 64'(acc_cyc[3]));
    end
    chk("ren_ext_zero", {62'd0, ren_ext, ren_ext_2}, 64'd0);
  endtask

  task automatic do_halt();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_ignored_in_run", {63'd0, cpu_enable}, 64'd1);
    chk("ready_low_in_run", {63'd0, in_ready}, 64'd0);
    halt = 1'b1;
    @(negedge clk); halt = 1'b0;
    chk("halt_cpu_off", {63'd0, cpu_enable}, 64'd0);
    @(negedge clk);
    chk("halt_idle", {62'd0, busy, cpu_enable}, 64'd0);
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_ready"}, {63'd0, in_ready}, 64'd0);
    chk({tag, "_addr"}, addr_ext | addr_ext_2, 64'd0);
    chk({tag, "_wdata"}, {32'd0, wdata_ext} | wdata_ext_2, 64'd0);
    chk({tag, "_ctl"}, {58'd0, wen_ext, wen_ext_2, ren_ext, ren_ext_2, cpu_enable, error}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_chk("reset");
    arst_n = 1'b1;

    stream = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
               8'h05, 8'h06, 8'h07, 8'h08};
    run_load(0);
    chk("basic_w0", wi_data.size() > 0 ? wi_data[0] : 64'hx, 64'h0000_0013);
    chk("basic_w1", wi_data.size() > 1 ? wi_data[1] : 64'hx, 64'h0010_0093);
    chk("basic_d0", wd_data.size() > 0 ? wd_data[0] : 64'hx, 64'h0807_0605_0403_0201);
    do_halt();
    run_load(50);
    do_halt();

    make_stream(0, 0, 1'b1);
    run_load(0);
    do_halt();

    make_stream(IMAX + 1, 0, 1'b0);
    run_load(0);
    make_stream(1, 0, 1'b1);
    run_load(0);
    do_halt();

    make_stream(0, DMAX + 1, 1'b0);
    run_load(30);
    make_stream(IMAX, 1, 1'b1);
    run_load(0);
    do_halt();

    for (int k = 0; k < 8; k++) begin
      make_stream($urandom_range(0, 6), $urandom_range(0, 4), 1'b1);
      run_load($urandom_range(0, 70));
      do_halt();
    end

    make_stream(3, 1, 1'b1);
    begin_load();
    send_bytes(20, 10);
    #2 arst_n = 1'b0;
    start = 1'b1;
    #1 reset_chk("midload");
    @(negedge clk);
    @(negedge clk); arst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("start_during_reset", {63'd0, busy}, 64'd0);
    make_stream(2, 1, 1'b1);
    run_load(20);
    do_halt();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
